// File: rtl/imem_port_arbiter.sv
// Single-port instruction/data RAM arbiter: fetch vs load/store, one access per cycle.
// Optional stall counters are enabled by defining IMEM_ARB_PERF_EN.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 17,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              fetch_flush_i,
  output logic              fetch_gnt_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  output logic              fetch_rvalid_o,
  input  logic              ls_valid_i,
  input  logic              ls_store_en_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_fetch_stall_o,
  output logic [15:0]       perf_ls_stall_o
`endif
);

  localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  owner_e              owner_q;
  logic [STREAK_W-1:0] streak_q;
  logic                streak_full;
  logic                fetch_win;
  logic                ls_win;
  logic                ls_wr;

  // Winner selection; state updates use the ungated winners, outputs are gated by reset.
  always_comb begin
    streak_full = (streak_q == STREAK_W'(MAX_LS_STREAK));
    fetch_win   = fetch_req_i & ~fetch_flush_i & (~ls_valid_i | streak_full);
    ls_win      = ls_valid_i & ~fetch_win;
    ls_wr       = ls_win & ls_store_en_i;
  end

  always_comb begin
    fetch_gnt_o    = 1'b0;
    ls_gnt_o       = 1'b0;
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    fetch_rvalid_o = 1'b0;
    ls_rvalid_o    = 1'b0;
    fetch_rdata_o  = '0;
    ls_rdata_o     = '0;
    if (!rst) begin
      fetch_gnt_o    = fetch_win;
      ls_gnt_o       = ls_win;
      mem_en_o       = fetch_win | ls_win;
      mem_we_o       = ls_wr;
      if (fetch_win) begin
        mem_addr_o = fetch_addr_i;
      end else if (ls_win) begin
        mem_addr_o = ls_addr_i;
      end
      if (ls_wr) begin
        mem_wdata_o = ls_wdata_i;
      end
      // A restart in the response cycle squashes the in-flight fetch return.
      fetch_rvalid_o = (owner_q == OWN_FETCH) & ~fetch_flush_i;
      ls_rvalid_o    = (owner_q == OWN_LOAD);
      fetch_rdata_o  = mem_rdata_i;
      ls_rdata_o     = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      if (fetch_win) begin
        owner_q <= OWN_FETCH;
      end else if (ls_win && !ls_store_en_i) begin
        owner_q <= OWN_LOAD;
      end else begin
        owner_q <= OWN_NONE;
      end
      // Streak only counts load/store wins that made a waiting fetch lose.
      if (fetch_win || !fetch_req_i) begin
        streak_q <= '0;
      end else if (ls_win && !streak_full) begin
        streak_q <= streak_q + STREAK_W'(1);
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_stall_o <= '0;
      perf_ls_stall_o    <= '0;
    end else begin
      if (fetch_req_i && !fetch_win && !(&perf_fetch_stall_o)) begin
        perf_fetch_stall_o <= perf_fetch_stall_o + 16'd1;
      end
      if (ls_valid_i && !ls_win && !(&perf_ls_stall_o)) begin
        perf_ls_stall_o <= perf_ls_stall_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus random traffic against a
// behavioural model (shadow memory, waiting-fetch counter, pending-response slot).
module tb_imem_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 17;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, fetch_flush, ls_valid, ls_store;
  logic [AW-1:0] fetch_addr, ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          fetch_gnt, fetch_rvalid, ls_gnt, ls_rvalid;
  logic [DW-1:0] fetch_rdata, ls_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_PERF_EN
  logic [15:0]   perf_f, perf_l;
`endif

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_flush_i(fetch_flush),
    .fetch_gnt_o(fetch_gnt), .fetch_rdata_o(fetch_rdata), .fetch_rvalid_o(fetch_rvalid),
    .ls_valid_i(ls_valid), .ls_store_en_i(ls_store), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rdata_o(ls_rdata),
    .ls_rvalid_o(ls_rvalid), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fetch_stall_o(perf_f), .perf_ls_stall_o(perf_l)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the arbiter.
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  // Reference model state
  logic [DW-1:0] ref_mem [0:1023];
  int            m_run;       // load/store wins in a row while fetch waited
  int            m_resp;      // 0 none, 1 fetch, 2 load response due this cycle
  logic [DW-1:0] m_data;
  int            nx_resp;
  logic [DW-1:0] nx_data;
  bit            nx_store;
  logic [AW-1:0] nx_addr;
  logic [DW-1:0] nx_wdata;
  logic          exp_fgnt, exp_lgnt, exp_en, exp_we, exp_fvalid, exp_lvalid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  int n_vec, n_err;

  task automatic model_eval();
    bit fwant;
    exp_fgnt = 0; exp_lgnt = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
    exp_fvalid = 0; exp_lvalid = 0; nx_resp = 0; nx_store = 0; nx_addr = '0; nx_wdata = '0;
    if (!rst) begin
      fwant      = fetch_req && !fetch_flush;
      exp_fgnt   = fwant && (!ls_valid || m_run >= MAXS);
      exp_lgnt   = ls_valid && !exp_fgnt;
      exp_en     = exp_fgnt || exp_lgnt;
      exp_we     = exp_lgnt && ls_store;
      exp_addr   = exp_fgnt ? fetch_addr : (exp_lgnt ? ls_addr : '0);
      exp_wdata  = exp_we ? ls_wdata : '0;
      exp_fvalid = (m_resp == 1) && !fetch_flush;
      exp_lvalid = (m_resp == 2);
      nx_resp    = exp_fgnt ? 1 : ((exp_lgnt && !ls_store) ? 2 : 0);
      nx_data    = ref_mem[exp_addr];
      nx_store   = exp_we;
      nx_addr    = exp_addr;
      nx_wdata   = exp_wdata;
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_run = 0; m_resp = 0;
    end else begin
      if (exp_fgnt || !fetch_req) m_run = 0;
      else if (exp_lgnt && m_run < MAXS) m_run++;
      m_resp = nx_resp;
      m_data = nx_data;
      if (nx_store) ref_mem[nx_addr] = nx_wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic idle_inputs();
    fetch_req = 0; fetch_flush = 0; fetch_addr = '0;
    ls_valid = 0; ls_store = 0; ls_addr = '0; ls_wdata = '0;
  endtask

  task automatic test_reset();
    tick();
    rst = 0;
    ls_valid = 1; ls_store = 0; ls_addr = 10'h5;
    settle();
    n_vec++;
    if (ls_gnt !== 1'b1) begin
      n_err++; $display("FAIL reset_preload ls_gnt got %b exp 1", ls_gnt);
    end
    tick();
    rst = 1;
    settle();
    n_vec++;
    if ({fetch_gnt, fetch_rdata, fetch_rvalid, ls_gnt, ls_rdata, ls_rvalid,
         mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs en=%b gnt=%b rv=%b addr=%h exp all 0",
               mem_en, ls_gnt, ls_rvalid, mem_addr);
    end
    tick();
    rst = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_vec++;
      if ({ls_rvalid, fetch_rvalid, mem_en} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_release cyc %0d ls_rvalid=%b fetch_rvalid=%b en=%b exp 000",
                 i, ls_rvalid, fetch_rvalid, mem_en);
      end
      tick();
    end
    settle();
  endtask

  task automatic test_store_load();
    tick();
    ls_valid = 1; ls_store = 1; ls_addr = 10'h2; ls_wdata = 17'h10005;
    settle();
    n_vec++;
    if ({ls_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'h2, 17'h10005}) begin
      n_err++;
      $display("FAIL store gnt=%b we=%b addr=%h wdata=%h exp 1 1 002 10005",
               ls_gnt, mem_we, mem_addr, mem_wdata);
    end
    tick();
    ls_store = 0; ls_wdata = '0;
    settle();
    n_vec++;
    if ({ls_gnt, mem_en, mem_we, mem_addr, ls_rvalid} !== {3'b110, 10'h2, 1'b0}) begin
      n_err++;
      $display("FAIL load_issue gnt=%b we=%b addr=%h rvalid=%b exp 1 0 002 0",
               ls_gnt, mem_we, mem_addr, ls_rvalid);
    end
    tick();
    idle_inputs();
    settle();
    n_vec++;
    if ({ls_rvalid, fetch_rvalid, ls_rdata} !== {2'b10, 17'h10005}) begin
      n_err++;
      $display("FAIL load_resp rvalid=%b fetch_rvalid=%b rdata=%h exp 1 0 10005",
               ls_rvalid, fetch_rvalid, ls_rdata);
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 16; a++) begin
      tick();
      ls_valid = 1; ls_store = 1; ls_addr = AW'(a); ls_wdata = DW'($urandom);
      settle();
      n_vec++;
      if ({ls_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, AW'(a), ls_wdata}) begin
        n_err++;
        $display("FAIL fill a=%0d gnt=%b we=%b addr=%h wdata=%h", a, ls_gnt, mem_we,
                 mem_addr, mem_wdata);
      end
    end
    tick();
    idle_inputs();
    settle();
  endtask

  task automatic test_streak();
    bit pat [10];
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      tick();
      fetch_req = 1; fetch_addr = 10'h3;
      ls_valid = 1; ls_store = 0; ls_addr = 10'h4;
      settle();
      n_vec++;
      if ({fetch_gnt, ls_gnt} !== {pat[i], !pat[i]}) begin
        n_err++;
        $display("FAIL streak cyc %0d fetch_gnt=%b ls_gnt=%b exp %b %b",
                 i, fetch_gnt, ls_gnt, pat[i], !pat[i]);
      end
      if (i > 0) begin
        n_vec++;
        if ({fetch_rvalid, ls_rvalid} !== {pat[i-1], !pat[i-1]}) begin
          n_err++;
          $display("FAIL streak_rvalid cyc %0d fetch_rvalid=%b ls_rvalid=%b exp %b %b",
                   i, fetch_rvalid, ls_rvalid, pat[i-1], !pat[i-1]);
        end
      end
    end
    tick();
    idle_inputs();
    settle();
    n_vec++;
    if ({fetch_rvalid, ls_rvalid, fetch_rdata} !== {2'b10, ref_mem[3]}) begin
      n_err++;
      $display("FAIL streak_last fetch_rvalid=%b ls_rvalid=%b rdata=%h exp 1 0 %h",
               fetch_rvalid, ls_rvalid, fetch_rdata, ref_mem[3]);
    end
  endtask

  task automatic test_flush();
    tick();
    fetch_req = 1; fetch_addr = 10'h7;
    settle();
    n_vec++;
    if (fetch_gnt !== 1'b1) begin
      n_err++; $display("FAIL flush_issue fetch_gnt got %b exp 1", fetch_gnt);
    end
    tick();
    fetch_flush = 1; fetch_addr = 10'h8;
    settle();
    n_vec++;
    if ({fetch_rvalid, fetch_gnt, mem_en} !== 3'b000) begin
      n_err++;
      $display("FAIL flush_squash rvalid=%b gnt=%b en=%b exp 000", fetch_rvalid, fetch_gnt, mem_en);
    end
    tick();
    idle_inputs();
    settle();
    n_vec++;
    if (fetch_rvalid !== 1'b0) begin
      n_err++; $display("FAIL flush_after fetch_rvalid got %b exp 0", fetch_rvalid);
    end
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 9; i++) begin
      tick();
      fetch_req = (i < 8); fetch_addr = (i < 8) ? AW'(i) : '0;
      settle();
      if (i < 8) begin
        n_vec++;
        if ({fetch_gnt, mem_addr} !== {1'b1, AW'(i)}) begin
          n_err++;
          $display("FAIL stream_gnt i=%0d gnt=%b addr=%h exp 1 %h", i, fetch_gnt, mem_addr, i);
        end
      end
      if (i > 0) begin
        n_vec++;
        if ({fetch_rvalid, fetch_rdata} !== {1'b1, ref_mem[i-1]}) begin
          n_err++;
          $display("FAIL stream_data i=%0d rvalid=%b rdata=%h exp 1 %h",
                   i, fetch_rvalid, fetch_rdata, ref_mem[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit f_keep, l_keep;
    for (int c = 0; c < 600; c++) begin
      f_keep = fetch_req && !exp_fgnt && !fetch_flush;
      l_keep = ls_valid && !exp_lgnt;
      tick();
      if (!f_keep) begin
        fetch_req  = ($urandom_range(0, 2) != 0);
        fetch_addr = AW'($urandom_range(0, 15));
      end
      fetch_flush = ($urandom_range(0, 9) == 0);
      if (!l_keep) begin
        ls_valid = ($urandom_range(0, 1) == 1);
        ls_store = ($urandom_range(0, 2) == 0);
        ls_addr  = AW'($urandom_range(0, 15));
        ls_wdata = DW'($urandom);
      end
      settle();
      n_vec++;
      if ({fetch_gnt, ls_gnt, mem_en, mem_we, mem_addr, mem_wdata, fetch_rvalid, ls_rvalid} !==
          {exp_fgnt, exp_lgnt, exp_en, exp_we, exp_addr, exp_wdata, exp_fvalid, exp_lvalid}) begin
        n_err++;
        $display("FAIL rnd_ctrl cyc %0d got fg=%b lg=%b en=%b we=%b a=%h wd=%h frv=%b lrv=%b exp fg=%b lg=%b en=%b we=%b a=%h wd=%h frv=%b lrv=%b",
                 c, fetch_gnt, ls_gnt, mem_en, mem_we, mem_addr, mem_wdata, fetch_rvalid, ls_rvalid,
                 exp_fgnt, exp_lgnt, exp_en, exp_we, exp_addr, exp_wdata, exp_fvalid, exp_lvalid);
      end
      if (exp_fvalid) begin
        n_vec++;
        if (fetch_rdata !== m_data) begin
          n_err++; $display("FAIL rnd_fdata cyc %0d got %h exp %h", c, fetch_rdata, m_data);
        end
      end
      if (exp_lvalid) begin
        n_vec++;
        if (ls_rdata !== m_data) begin
          n_err++; $display("FAIL rnd_ldata cyc %0d got %h exp %h", c, ls_rdata, m_data);
        end
      end
    end
    tick();
    idle_inputs();
    settle();
  endtask

`ifdef IMEM_ARB_PERF_EN
  task automatic test_perf();
    tick();
    idle_inputs();
    rst = 1;
    settle();
    tick();
    rst = 0;
    settle();
    n_vec++;
    if ({perf_f, perf_l} !== 32'h0) begin
      n_err++; $display("FAIL perf_clear f=%0d l=%0d exp 0 0", perf_f, perf_l);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      fetch_req = 1; fetch_addr = 10'h1;
      ls_valid = 1; ls_store = 0; ls_addr = 10'h2;
      settle();
    end
    tick();
    idle_inputs();
    settle();
    n_vec++;
    if ({perf_f, perf_l} !== {16'd3, 16'd0}) begin
      n_err++; $display("FAIL perf_count f=%0d l=%0d exp 3 0", perf_f, perf_l);
    end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1;
    idle_inputs();
    m_run = 0; m_resp = 0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_eval();
    n_vec++;
    if ({fetch_gnt, fetch_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_err++; $display("FAIL reset_state en=%b we=%b addr=%h exp 0", mem_en, mem_we, mem_addr);
    end
    test_reset();
    test_store_load();
    test_fill();
    test_streak();
    test_flush();
    test_fetch_stream();
    test_random();
`ifdef IMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
